// File: rtl/uart_pkg.sv
// Shared types, limits and config-clamping helpers for the UART TX slice.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

  localparam int         CPB_W_DFLT   = 16;
  localparam logic [3:0] DATA_LEN_MIN = 4'd5;
  localparam logic [3:0] DATA_LEN_MAX = 4'd8;

  typedef struct packed {
    logic       parity_en;
    logic       parity_even;
    logic [3:0] data_len;
    logic [1:0] stop_len;
  } uart_config;

  typedef struct packed {
    logic [CPB_W_DFLT-1:0] tx_clks_per_bit;
    logic [CPB_W_DFLT-1:0] rx_clks_per_bit;
  } uart_config_bdgen;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state;

  function automatic logic [3:0] clamp_data_len(input logic [3:0] len);
    if (len < DATA_LEN_MIN) return DATA_LEN_MIN;
    if (len > DATA_LEN_MAX) return DATA_LEN_MAX;
    return len;
  endfunction

  function automatic logic [1:0] clamp_stop_len(input logic [1:0] len);
    return (len >= 2'd2) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-clock pulse on the clock where count reaches N-1.
// Pulse is combinational from the count; disabling clears the count; no backpressure.
module uart_baud_tick #(
  parameter int CPB_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [CPB_W-1:0] clks_per_bit,
  output logic             pls
);

  logic [CPB_W-1:0] cnt;
  logic             wrap;

  // >= rather than == so shrinking clks_per_bit mid-count wraps at once; N of 0 or 1 pulses every clock.
  assign wrap = (clks_per_bit <= CPB_W'(1)) || (cnt >= clks_per_bit - CPB_W'(1));
  assign pls  = en & wrap;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt <= '0;
    else if (!en || wrap)
      cnt <= '0;
    else
      cnt <= cnt + CPB_W'(1);
  end

endmodule

// File: rtl/uart_tx_baud_top.sv
// UART TX: baud ticks plus frame FSM; frames advance only on pls_tx, so each bit lasts N clocks.
// valid is taken only in IDLE or on the final stop tick (no buffering); UART_BDGEN_RX_EN builds the RX tick.
module uart_tx_baud_top
  import uart_pkg::*;
#(
  parameter int CPB_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [CPB_W-1:0]  tx_clks_per_bit,
  input  logic [CPB_W-1:0]  rx_clks_per_bit,
  input  logic              en_rxcnt,
  input  logic              parity_en,
  input  logic              parity_even,
  input  logic [3:0]        data_len,
  input  logic [1:0]        stop_len,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              uart_txd,
  output logic              tx_busy,
  output logic              empty_tsr,
  output logic              tx_done,
  output logic              pls_tx,
  output logic              pls_rx
);

  uart_tx_state      state, state_nxt;
  uart_config        cfg, cfg_nxt;
  logic [DATA_W-1:0] tsr, tsr_nxt;
  logic [3:0]        bit_cnt, bit_nxt;
  logic              par_bit, par_nxt;
  logic              busy_nxt, empty_nxt;
  logic              load;
  logic [3:0]        ld_len;
  logic              ld_par;

  uart_baud_tick #(.CPB_W(CPB_W)) u_tx_tick (
    .clk          (clk),
    .rstn         (rstn),
    .en           (1'b1),
    .clks_per_bit (tx_clks_per_bit),
    .pls          (pls_tx)
  );

`ifdef UART_BDGEN_RX_EN
  uart_baud_tick #(.CPB_W(CPB_W)) u_rx_tick (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en_rxcnt),
    .clks_per_bit (rx_clks_per_bit),
    .pls          (pls_rx)
  );
`else
  logic rx_unused;
  assign rx_unused = ^{en_rxcnt, rx_clks_per_bit};
  assign pls_rx    = 1'b0;
`endif

  // Parity is resolved at load time over only the bits that will be sent.
  always_comb begin
    ld_len = clamp_data_len(data_len);
    ld_par = ~parity_even;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(ld_len)) ld_par = ld_par ^ data[i];
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_nxt   = cfg;
    tsr_nxt   = tsr;
    bit_nxt   = bit_cnt;
    par_nxt   = par_bit;
    busy_nxt  = tx_busy;
    empty_nxt = empty_tsr;
    tx_done   = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: if (pls_tx && valid) load = 1'b1;
      START: if (pls_tx) begin
        state_nxt = DATA;
        bit_nxt   = '0;
      end
      DATA: if (pls_tx) begin
        tsr_nxt = tsr >> 1;
        if (bit_cnt == cfg.data_len - 4'd1) begin
          bit_nxt   = '0;
          state_nxt = cfg.parity_en ? PARITY : STOP;
        end else begin
          bit_nxt = bit_cnt + 4'd1;
        end
      end
      PARITY: if (pls_tx) begin
        state_nxt = STOP;
        bit_nxt   = '0;
      end
      STOP: if (pls_tx) begin
        if (bit_cnt == {2'b00, cfg.stop_len} - 4'd1) begin
          tx_done   = 1'b1;
          empty_nxt = 1'b1;
          if (valid) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end else begin
          bit_nxt = bit_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      state_nxt            = START;
      tsr_nxt              = data;
      cfg_nxt.parity_en    = parity_en;
      cfg_nxt.parity_even  = parity_even;
      cfg_nxt.data_len     = ld_len;
      cfg_nxt.stop_len     = clamp_stop_len(stop_len);
      par_nxt              = ld_par;
      bit_nxt              = '0;
      busy_nxt             = 1'b1;
      empty_nxt            = 1'b0;
    end
  end

  // Line level decodes straight from state so an async reset forces idle-high immediately.
  always_comb begin
    case (state)
      START:   uart_txd = 1'b0;
      DATA:    uart_txd = tsr[0];
      PARITY:  uart_txd = par_bit;
      default: uart_txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cfg       <= '0;
      tsr       <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      tx_busy   <= 1'b0;
      empty_tsr <= 1'b1;
    end else begin
      state     <= state_nxt;
      cfg       <= cfg_nxt;
      tsr       <= tsr_nxt;
      bit_cnt   <= bit_nxt;
      par_bit   <= par_nxt;
      tx_busy   <= busy_nxt;
      empty_tsr <= empty_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_baud_top.sv
// Directed bench for uart_tx_baud_top: baud pulses, frame bit patterns, clamping, abort.
// Outputs are sampled on the falling edge; expected frames are hand-written bit vectors.
module tb_uart_tx_baud_top;

  localparam int CPB = 32;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] tx_clks_per_bit;
  logic [15:0] rx_clks_per_bit;
  logic        en_rxcnt;
  logic        parity_en;
  logic        parity_even;
  logic [3:0]  data_len;
  logic [1:0]  stop_len;
  logic        valid;
  logic [7:0]  data;
  logic        uart_txd;
  logic        tx_busy;
  logic        empty_tsr;
  logic        tx_done;
  logic        pls_tx;
  logic        pls_rx;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  uart_tx_baud_top dut (
    .clk             (clk),
    .rstn            (rstn),
    .tx_clks_per_bit (tx_clks_per_bit),
    .rx_clks_per_bit (rx_clks_per_bit),
    .en_rxcnt        (en_rxcnt),
    .parity_en       (parity_en),
    .parity_even     (parity_even),
    .data_len        (data_len),
    .stop_len        (stop_len),
    .valid           (valid),
    .data            (data),
    .uart_txd        (uart_txd),
    .tx_busy         (tx_busy),
    .empty_tsr       (empty_tsr),
    .tx_done         (tx_done),
    .pls_tx          (pls_tx),
    .pls_rx          (pls_rx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return pls_tx;
      1:       return pls_rx;
      default: return ~uart_txd;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int limit, input string tag);
    int i = 0;
    while (!sig(sel) && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk({tag, " seen"}, 32'(sig(sel)), 32'd1);
  endtask

  task automatic period(input int sel, input int limit, output int p);
    p = 0;
    do begin
      @(negedge clk);
      p++;
    end while (!sig(sel) && p < limit);
  endtask

  task automatic count_hi(input int sel, input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sig(sel)) c++;
    end
  endtask

  // Called on the first falling edge of START; returns on the first falling edge after the frame.
  task automatic run_frame(input logic [11:0] bits, input int nbits, input string tag);
    int done_at = -1;
    for (int n = 0; n < nbits * CPB; n++) begin
      if (n % CPB == CPB / 2)
        chk($sformatf("%s bit%0d", tag, n / CPB), 32'(uart_txd), 32'(bits[n / CPB]));
      if (tx_done && done_at < 0) done_at = n;
      @(negedge clk);
    end
    chk({tag, " tx_done time"}, done_at, nbits * CPB - 1);
    chk({tag, " tx_done pulse"}, 32'(tx_done), 32'd0);
  endtask

  initial begin
    int p;
    int c;
    rstn            = 1'b0;
    tx_clks_per_bit = 16'd32;
    rx_clks_per_bit = 16'd16;
    en_rxcnt        = 1'b0;
    parity_en       = 1'b0;
    parity_even     = 1'b0;
    data_len        = 4'd8;
    stop_len        = 2'd1;
    valid           = 1'b0;
    data            = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst uart_txd", 32'(uart_txd), 32'd1);
    chk("rst tx_busy", 32'(tx_busy), 32'd0);
    chk("rst empty_tsr", 32'(empty_tsr), 32'd1);
    chk("rst tx_done", 32'(tx_done), 32'd0);
    chk("rst pls_tx", 32'(pls_tx), 32'd0);
    chk("rst pls_rx", 32'(pls_rx), 32'd0);
    rstn = 1'b1;

    // TX baud pulse: period and width at N=32.
    wait_for(0, 100, "pls_tx first");
    period(0, 100, p);
    chk("pls_tx period 32", p, 32);
    count_hi(0, 32, c);
    chk("pls_tx one per 32", c, 1);

    // Shrinking N mid-count wraps on the same clock.
    repeat (20) @(negedge clk);
    tx_clks_per_bit = 16'd8;
    #1;
    chk("shrink wraps now", 32'(pls_tx), 32'd1);
    @(negedge clk);
    chk("shrink wrapped", 32'(pls_tx), 32'd0);
    wait_for(0, 20, "pls_tx n8");
    period(0, 20, p);
    chk("pls_tx period 8", p, 8);

    tx_clks_per_bit = 16'd1;
    #1;
    chk("n1 pls now", 32'(pls_tx), 32'd1);
    count_hi(0, 4, c);
    chk("n1 every clock", c, 4);
    tx_clks_per_bit = 16'd0;
    count_hi(0, 4, c);
    chk("n0 every clock", c, 4);
    tx_clks_per_bit = 16'd32;

`ifdef UART_BDGEN_RX_EN
    en_rxcnt = 1'b1;
    wait_for(1, 40, "pls_rx first");
    period(1, 40, p);
    chk("pls_rx period 16", p, 16);
    en_rxcnt = 1'b0;
    #1;
    chk("pls_rx gated", 32'(pls_rx), 32'd0);
    count_hi(1, 40, c);
    chk("pls_rx off count", c, 0);
`else
    en_rxcnt = 1'b1;
    count_hi(1, 40, c);
    chk("pls_rx tied low", c, 0);
    en_rxcnt = 1'b0;
`endif

    // 0x0F, 8 bits, even parity, 2 stops, valid held high -> back-to-back frame.
    data        = 8'h0F;
    data_len    = 4'd8;
    parity_en   = 1'b1;
    parity_even = 1'b1;
    stop_len    = 2'd2;
    valid       = 1'b1;
    wait_for(2, 100, "f1 start");
    chk("f1 busy", 32'(tx_busy), 32'd1);
    chk("f1 empty_tsr", 32'(empty_tsr), 32'd0);
    run_frame(12'b110000011110, 12, "f1");
    chk("b2b start", 32'(uart_txd), 32'd0);
    chk("b2b busy", 32'(tx_busy), 32'd1);

    // Mid-frame changes must not reach the frame in flight.
    parity_even = 1'b0;
    data        = 8'h01;
    valid       = 1'b0;
    run_frame(12'b110000011110, 12, "f2");
    chk("f2 idle txd", 32'(uart_txd), 32'd1);
    chk("f2 idle busy", 32'(tx_busy), 32'd0);
    chk("f2 idle empty", 32'(empty_tsr), 32'd1);

    data        = 8'h0F;
    parity_even = 1'b0;
    valid       = 1'b1;
    wait_for(2, 100, "f3 start");
    valid = 1'b0;
    run_frame(12'b111000011110, 12, "f3 odd");

    data        = 8'h01;
    parity_even = 1'b1;
    valid       = 1'b1;
    wait_for(2, 100, "f4 start");
    valid = 1'b0;
    run_frame(12'b111000000010, 12, "f4 even01");

    data      = 8'hFF;
    data_len  = 4'd5;
    parity_en = 1'b0;
    stop_len  = 2'd1;
    valid     = 1'b1;
    wait_for(2, 100, "f5 start");
    valid = 1'b0;
    run_frame(12'b000001111110, 7, "f5 len5");

    // Clamp low: len 3 -> 5, stop 0 -> 1; bits 7:5 must not enter parity.
    data        = 8'hE0;
    data_len    = 4'd3;
    parity_en   = 1'b1;
    parity_even = 1'b1;
    stop_len    = 2'd0;
    valid       = 1'b1;
    wait_for(2, 100, "f6 start");
    valid = 1'b0;
    run_frame(12'b000010000000, 8, "f6 clamp lo");

    data      = 8'hA5;
    data_len  = 4'd12;
    parity_en = 1'b0;
    stop_len  = 2'd3;
    valid     = 1'b1;
    wait_for(2, 100, "f7 start");
    valid = 1'b0;
    run_frame(12'b011101001010, 11, "f7 clamp hi");

    // Abort mid-DATA: the line must go high asynchronously.
    data     = 8'h00;
    data_len = 4'd8;
    stop_len = 2'd1;
    valid    = 1'b1;
    wait_for(2, 100, "abort start");
    valid = 1'b0;
    repeat (42) @(negedge clk);
    chk("abort pre txd", 32'(uart_txd), 32'd0);
    rstn = 1'b0;
    #1;
    chk("abort txd", 32'(uart_txd), 32'd1);
    chk("abort busy", 32'(tx_busy), 32'd0);
    chk("abort empty", 32'(empty_tsr), 32'd1);
    repeat (3) @(negedge clk);
    rstn  = 1'b1;
    data  = 8'h0F;
    valid = 1'b1;
    wait_for(2, 100, "post abort start");
    valid = 1'b0;
    run_frame(12'b001000011110, 10, "post abort");
    chk("final idle busy", 32'(tx_busy), 32'd0);
    chk("final idle txd", 32'(uart_txd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
